// File: rtl/toy_pkg.sv
// Shared definitions for the toy ALU and its passive checker.
// The ALU and the checker both call toy_model, so prediction and design cannot drift.
package toy_pkg;

    localparam int TOY_MAX_W = 32;

    typedef logic [TOY_MAX_W-1:0] toy_word_t;

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } chk_state_t;

    // op=1: OR previous input with current; op=0: keep previous input only when in[0] is set.
    function automatic toy_word_t toy_model(input logic op, input toy_word_t tmp, input toy_word_t in_w);
        toy_word_t res;
        res = op ? (tmp | in_w) : (tmp & {TOY_MAX_W{in_w[0]}});
        return res;
    endfunction

endpackage

// File: rtl/toy_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Updates one cycle after inc; clr wins over inc.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/toy_checker.sv
// Passive scoreboard for the toy ALU: predicts out two edges after op/in and flags sticky mismatches.
// Needs two warm-up edges after enable because the ALU has no reset.
module toy_checker
    import toy_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             op,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] out,
    output logic             fail,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic [1:0]       state
);

    chk_state_t       state_q, state_d;
    logic             fail_q, fail_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_obs_q, first_obs_d;
    logic [WIDTH-1:0] tmp_m_q, tmp_m_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch;
    logic             do_cmp;
    logic             fail_inc;

    // Model history only advances while enabled; a disable forces a fresh warm-up.
    always_comb begin
        tmp_m_d = tmp_m_q;
        exp_d   = exp_q;
        if (chk_en) begin
            tmp_m_d = in;
            exp_d   = WIDTH'(toy_model(op, toy_word_t'(tmp_m_q), toy_word_t'(in)));
        end
    end

    // Case inequality so an unknown out is reported rather than silently passing.
    assign mismatch = (out !== exp_q);

    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        do_cmp      = 1'b0;
        fail_inc    = 1'b0;
        if (clr) begin
            state_d     = WARM0;
            fail_d      = 1'b0;
            first_exp_d = '0;
            first_obs_d = '0;
        end else begin
            case (state_q)
                WARM0: begin
                    if (chk_en) begin
                        state_d = WARM1;
                    end
                end
                WARM1: begin
                    state_d = chk_en ? CHECK : WARM0;
                end
                CHECK: begin
                    if (!chk_en) begin
                        state_d = WARM0;
                    end else begin
                        do_cmp = 1'b1;
                        if (mismatch) begin
                            fail_d      = 1'b1;
                            fail_inc    = 1'b1;
                            first_exp_d = exp_q;
                            first_obs_d = out;
                            state_d     = FAIL;
                        end
                    end
                end
                FAIL: begin
                    if (chk_en) begin
                        do_cmp   = 1'b1;
                        fail_inc = mismatch;
                    end
                end
                default: begin
                    state_d = WARM0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WARM0;
            fail_q      <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
            tmp_m_q     <= '0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
            tmp_m_q     <= tmp_m_d;
            exp_q       <= exp_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (fail_inc),
        .clr   (clr),
        .cnt   (fail_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (do_cmp),
        .clr   (clr),
        .cnt   (chk_cnt)
    );

    assign fail      = fail_q;
    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
    assign state     = state_q;

endmodule

// File: tb/tb_toy_checker.sv
// Directed bench: a behavioural toy ALU feeds the checker, out can be corrupted per cycle.
// Expectations are queued per target cycle and checked by an independent monitor.
module tb_toy_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       chk_en;
    logic       clr;
    logic       op;
    logic [1:0] in_v;
    logic [1:0] alu_tmp;
    logic [1:0] alu_out;
    logic [1:0] out_v;
    logic       cor;
    logic [1:0] cval;

    logic       fail;
    logic [7:0] fail_cnt;
    logic [7:0] chk_cnt;
    logic [1:0] first_exp;
    logic [1:0] first_obs;
    logic [1:0] state;

    logic       s_fail;
    logic [1:0] s_fail_cnt;
    logic [1:0] s_chk_cnt;
    logic [1:0] s_first_exp;
    logic [1:0] s_first_obs;
    logic [1:0] s_state;

    typedef struct {
        int         tgt;
        string      name;
        logic [1:0] st;
        logic       fl;
        logic [7:0] fc;
        logic [7:0] cc;
        logic [1:0] fe;
        logic [1:0] fo;
        logic [1:0] sfc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   stepn = 0;

    always #5 clk = ~clk;

    // Reference toy ALU: no reset, registered tmp and out.
    always @(posedge clk) begin
        alu_tmp <= in_v;
        alu_out <= op ? (alu_tmp | in_v) : (alu_tmp & {2{in_v[0]}});
    end

    assign out_v = cor ? cval : alu_out;

    always @(posedge clk) cyc++;

    toy_checker #(.WIDTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .chk_en    (chk_en),
        .clr       (clr),
        .op        (op),
        .in        (in_v),
        .out       (out_v),
        .fail      (fail),
        .fail_cnt  (fail_cnt),
        .chk_cnt   (chk_cnt),
        .first_exp (first_exp),
        .first_obs (first_obs),
        .state     (state)
    );

    toy_checker #(.WIDTH(2), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .chk_en    (chk_en),
        .clr       (clr),
        .op        (op),
        .in        (in_v),
        .out       (out_v),
        .fail      (s_fail),
        .fail_cnt  (s_fail_cnt),
        .chk_cnt   (s_chk_cnt),
        .first_exp (s_first_exp),
        .first_obs (s_first_obs),
        .state     (s_state)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, expv);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic o, input logic [1:0] i,
                        input logic cr, input logic [1:0] cv,
                        input logic [1:0] est, input logic ef, input int efc, input int ecc,
                        input logic [1:0] efe, input logic [1:0] efo, input int esfc);
        exp_t x;
        @(negedge clk);
        chk_en = e;
        clr    = c;
        op     = o;
        in_v   = i;
        cor    = cr;
        cval   = cv;
        stepn++;
        x.tgt  = cyc + 1;
        x.name = $sformatf("E%0d", stepn);
        x.st   = est;
        x.fl   = ef;
        x.fc   = efc[7:0];
        x.cc   = ecc[7:0];
        x.fe   = efe;
        x.fo   = efo;
        x.sfc  = esfc[1:0];
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        #1;
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            x = q.pop_front();
            if (x.tgt < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.stale: checked at cycle %0d, want cycle %0d", x.name, cyc, x.tgt);
            end else begin
                chk({x.name, ".state"},     8'(state),      8'(x.st));
                chk({x.name, ".fail"},      8'(fail),       8'(x.fl));
                chk({x.name, ".fail_cnt"},  fail_cnt,       x.fc);
                chk({x.name, ".chk_cnt"},   chk_cnt,        x.cc);
                chk({x.name, ".first_exp"}, 8'(first_exp),  8'(x.fe));
                chk({x.name, ".first_obs"}, 8'(first_obs),  8'(x.fo));
                chk({x.name, ".sat_fcnt"},  8'(s_fail_cnt), 8'(x.sfc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b0;
        chk_en = 1'b0;
        clr    = 1'b0;
        op     = 1'b0;
        in_v   = 2'b00;
        cor    = 1'b0;
        cval   = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst.state",     8'(state),     8'd0);
        chk("rst.fail",      8'(fail),      8'd0);
        chk("rst.fail_cnt",  fail_cnt,      8'd0);
        chk("rst.chk_cnt",   chk_cnt,       8'd0);
        chk("rst.first_exp", 8'(first_exp), 8'd0);
        chk("rst.first_obs", 8'(first_obs), 8'd0);
        reset = 1'b1;

        //   en clr op in    cor cval   st fl fc  cc  fexp   fobs   satfc
        // Warm-up with op=1, first compare on the third enabled edge
        step(1, 0, 1, 2'b01, 0, 2'b00, 1, 0, 0,  0,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b11, 0, 2'b00, 2, 0, 0,  0,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b10, 0, 2'b00, 2, 0, 0,  1,  2'b00, 2'b00, 0);
        // op=0 masking
        step(1, 0, 0, 2'b11, 0, 2'b00, 2, 0, 0,  2,  2'b00, 2'b00, 0);
        step(1, 0, 0, 2'b10, 0, 2'b00, 2, 0, 0,  3,  2'b00, 2'b00, 0);
        step(1, 0, 0, 2'b11, 0, 2'b00, 2, 0, 0,  4,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b01, 0, 2'b00, 2, 0, 0,  5,  2'b00, 2'b00, 0);
        step(1, 0, 0, 2'b01, 0, 2'b00, 2, 0, 0,  6,  2'b00, 2'b00, 0);
        // Injected faults: expected 01, observed 11 then 00
        step(1, 0, 0, 2'b01, 1, 2'b11, 3, 1, 1,  7,  2'b01, 2'b11, 1);
        step(1, 0, 0, 2'b01, 1, 2'b00, 3, 1, 2,  8,  2'b01, 2'b11, 2);
        step(1, 0, 0, 2'b01, 0, 2'b00, 3, 1, 2,  9,  2'b01, 2'b11, 2);
        step(1, 0, 0, 2'b01, 1, 2'b10, 3, 1, 3,  10, 2'b01, 2'b11, 3);
        // clr beats a same-cycle mismatch
        step(1, 1, 0, 2'b01, 1, 2'b10, 0, 0, 0,  0,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b10, 0, 2'b00, 1, 0, 0,  0,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b01, 0, 2'b00, 2, 0, 0,  0,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b00, 0, 2'b00, 2, 0, 0,  1,  2'b00, 2'b00, 0);
        // chk_en drop with corrupted out, then re-warm
        step(0, 0, 1, 2'b11, 1, 2'b10, 0, 0, 0,  1,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b10, 0, 2'b00, 1, 0, 0,  1,  2'b00, 2'b00, 0);
        step(1, 0, 1, 2'b01, 0, 2'b00, 2, 0, 0,  1,  2'b00, 2'b00, 0);
        step(1, 0, 0, 2'b11, 0, 2'b00, 2, 0, 0,  2,  2'b00, 2'b00, 0);
        step(1, 0, 0, 2'b11, 0, 2'b00, 2, 0, 0,  3,  2'b00, 2'b00, 0);
        // Five mismatches: narrow instance saturates at 3
        step(1, 0, 0, 2'b11, 1, 2'b00, 3, 1, 1,  4,  2'b11, 2'b00, 1);
        step(1, 0, 0, 2'b11, 1, 2'b00, 3, 1, 2,  5,  2'b11, 2'b00, 2);
        step(1, 0, 0, 2'b11, 1, 2'b00, 3, 1, 3,  6,  2'b11, 2'b00, 3);
        step(1, 0, 0, 2'b11, 1, 2'b00, 3, 1, 4,  7,  2'b11, 2'b00, 3);
        step(1, 0, 0, 2'b11, 1, 2'b00, 3, 1, 5,  8,  2'b11, 2'b00, 3);
        step(1, 0, 0, 2'b11, 0, 2'b00, 3, 1, 5,  9,  2'b11, 2'b00, 3);
        // FAIL holds with no compare while disabled
        step(0, 0, 0, 2'b11, 1, 2'b00, 3, 1, 5,  9,  2'b11, 2'b00, 3);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end

        // Asynchronous reset mid-cycle, observed before any clock edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.state",     8'(state),      8'd0);
        chk("arst.fail",      8'(fail),       8'd0);
        chk("arst.fail_cnt",  fail_cnt,       8'd0);
        chk("arst.chk_cnt",   chk_cnt,        8'd0);
        chk("arst.first_exp", 8'(first_exp),  8'd0);
        chk("arst.first_obs", 8'(first_obs),  8'd0);
        chk("arst.sat_fcnt",  8'(s_fail_cnt), 8'd0);
        chk("arst.sat_fail",  8'(s_fail),     8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
